// File: rtl/sdr_reply_pkg.sv
// Shared types for the reply scheduler that owns the Ethernet reply transmitter.
// One-hot state encoding and reply type indices.
package sdr_reply_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_GRANT = 5'b00010,
    S_SEND  = 5'b00100,
    S_ACK   = 5'b01000,
    S_GAP   = 5'b10000
  } state_t;

  localparam int I_IDLE  = 0;
  localparam int I_GRANT = 1;
  localparam int I_SEND  = 2;
  localparam int I_ACK   = 3;
  localparam int I_GAP   = 4;

  localparam int RT_DISCOVERY  = 0;
  localparam int RT_ERASE_DONE = 1;
  localparam int RT_PROG_ACK   = 2;

endpackage

// File: rtl/sdr_reply_scheduler_rr_arbiter.sv
// Combinational round-robin picker: lowest index at or after
// rr_ptr (wrapping) with its request high wins.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int PW = $clog2(NUM_REQ);

  int            k;
  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    k      = 0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      idx = PW'(k);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/sdr_reply_scheduler.sv
// Shares the single reply transmitter between the protocol-control
// requesters; round-robin grant, timeout on stuck handshakes, idle gap.
module sdr_reply_scheduler
  import sdr_reply_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int TIMEOUT_W  = 27,
  parameter int GAP_CYCLES = 16
) (
  input  logic                       rx_clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       reply_start,
  output logic [$clog2(NUM_REQ)-1:0] reply_type,
  input  logic                       tx_accept,
  input  logic                       tx_busy,
  output logic                       timeout_err,
  output logic                       sched_busy
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t               state;
  state_t               state_nxt;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [TW-1:0]        type_q;
  logic [TW-1:0]        rr_ptr;
  logic                 err_q;

  logic [TW-1:0] arb_winner;
  logic          arb_valid;
  logic          grant;
  logic          accept;
  logic          set_err;
  logic          to_wrap;
  logic          gap_done;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req   (req),
    .rr_ptr(rr_ptr),
    .winner(arb_winner),
    .valid (arb_valid)
  );

  assign to_wrap  = &to_cnt;
  assign gap_done = (gap_cnt == GW'(GAP_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    accept    = 1'b0;
    set_err   = 1'b0;
    unique case (1'b1)
      state[I_IDLE]: begin
        if (arb_valid && !tx_busy) begin
          grant     = 1'b1;
          state_nxt = S_GRANT;
        end
      end
      state[I_GRANT]: begin
        if (tx_accept) begin
          accept    = 1'b1;
          state_nxt = S_SEND;
        end else if (to_wrap) begin
          set_err   = 1'b1;
          state_nxt = S_ACK;
        end
      end
      state[I_SEND]: begin
        // first SEND cycle is skipped: tx_busy may lag the accept
        if (to_cnt != '0 && !tx_busy) begin
          state_nxt = S_ACK;
        end else if (to_wrap) begin
          set_err   = 1'b1;
          state_nxt = S_ACK;
        end
      end
      state[I_ACK]: begin
        state_nxt = S_GAP;
      end
      state[I_GAP]: begin
        if (gap_done) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (grant || accept) begin
      to_cnt <= '0;
    end else if (state[I_GRANT] || state[I_SEND]) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (state[I_ACK]) begin
      gap_cnt <= '0;
    end else if (state[I_GAP]) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      type_q <= '0;
      err_q  <= 1'b0;
    end else if (grant) begin
      type_q <= arb_winner;
      err_q  <= 1'b0;
    end else if (set_err) begin
      err_q  <= 1'b1;
    end
  end

  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (state[I_ACK]) begin
      rr_ptr <= (type_q == TW'(NUM_REQ - 1)) ? '0 : type_q + 1'b1;
    end
  end

  always_comb begin
    ack = '0;
    if (state[I_ACK]) ack[type_q] = 1'b1;
  end

  assign reply_start = state[I_GRANT];
  assign reply_type  = type_q;
  assign timeout_err = state[I_ACK] & err_q;
  assign sched_busy  = !state[I_IDLE];

endmodule

// File: tb/tb_sdr_reply_scheduler.sv
// Bench for sdr_reply_scheduler: vector table of reply transactions,
// ack scoreboard, plus reset and busy-hold sequences.
module tb_sdr_reply_scheduler;

  localparam int GAP = 16;

  logic       rx_clock  = 1'b0;
  logic       reset_n   = 1'b0;
  logic [2:0] req       = '0;
  logic       tx_accept = 1'b0;
  logic       tx_busy   = 1'b0;
  logic [2:0] ack;
  logic       reply_start;
  logic [1:0] reply_type;
  logic       timeout_err;
  logic       sched_busy;

  int checks = 0;
  int errors = 0;

  always #5 rx_clock = ~rx_clock;

  sdr_reply_scheduler #(
    .NUM_REQ   (3),
    .TIMEOUT_W (4),
    .GAP_CYCLES(GAP)
  ) dut (
    .rx_clock   (rx_clock),
    .reset_n    (reset_n),
    .req        (req),
    .ack        (ack),
    .reply_start(reply_start),
    .reply_type (reply_type),
    .tx_accept  (tx_accept),
    .tx_busy    (tx_busy),
    .timeout_err(timeout_err),
    .sched_busy (sched_busy)
  );

  typedef struct {
    logic [2:0] req;
    int         acc_dly;
    int         busy_len;
    bit         never_acc;
    bit         drop_early;
    logic [1:0] exp_type;
    bit         exp_err;
  } vec_t;

  typedef struct {
    logic [2:0] ack;
    bit         err;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int   cyc = 0;
  int   last_ack = -1;
  logic rs_q = 1'b0;

  always @(negedge rx_clock) begin
    exp_t e;
    if (reset_n && ack != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: ack %b with nothing expected", ack);
      end else begin
        e = sbq.pop_front();
        chk("sb_ack", int'(ack), int'(e.ack));
        chk("sb_err", int'(timeout_err), int'(e.err));
      end
      last_ack <= cyc;
    end
    if (reply_start && !rs_q && last_ack >= 0) begin
      checks++;
      if (cyc - last_ack < GAP + 2) begin
        errors++;
        $display("FAIL gap: %0d cycles ack->start, need >= %0d",
                 cyc - last_ack, GAP + 2);
      end
    end
    rs_q <= reply_start;
    cyc  <= cyc + 1;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sched_busy && n < 80) begin
      @(negedge rx_clock);
      n++;
    end
    if (sched_busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: scheduler still busy after %0d cycles", n);
    end
  endtask

  task automatic run_reply(input vec_t v);
    int   n;
    exp_t e;
    wait_idle();
    req = v.req;
    @(negedge rx_clock);
    chk("latency", int'(reply_start), 1);
    chk("type", int'(reply_type), int'(v.exp_type));
    e.ack = 3'b001 << v.exp_type;
    e.err = v.exp_err;
    sbq.push_back(e);
    if (v.drop_early) req[v.exp_type] = 1'b0;
    if (v.never_acc) begin
      n = 1;
      while (reply_start && n < 40) begin
        @(negedge rx_clock);
        if (reply_start) n++;
      end
      chk("grant_len", n, 16);
    end else begin
      repeat (v.acc_dly) @(negedge rx_clock);
      tx_accept = 1'b1;
      @(negedge rx_clock);
      tx_accept = 1'b0;
      chk("start_drop", int'(reply_start), 0);
      if (v.busy_len > 0) begin
        tx_busy = 1'b1;
        repeat (v.busy_len) @(negedge rx_clock);
        tx_busy = 1'b0;
        @(negedge rx_clock);
        chk("ack_timing", int'(ack), int'(e.ack));
      end else begin
        @(negedge rx_clock);
        chk("send_hold", int'(ack), 0);
      end
    end
    n = 0;
    while (ack == '0 && n < 40) begin
      @(negedge rx_clock);
      n++;
    end
    if (ack == '0) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: no ack after %0d cycles", n);
    end
    req = req & ~ack;
  endtask

  vec_t tbl[11];
  vec_t hv;
  int   cnt;

  initial begin
    tbl[0]  = '{3'b111, 0, 0,  1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{3'b110, 0, 0,  1'b0, 1'b0, 2'd1, 1'b0};
    tbl[2]  = '{3'b100, 0, 0,  1'b0, 1'b0, 2'd2, 1'b0};
    tbl[3]  = '{3'b001, 3, 10, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{3'b010, 0, 0,  1'b1, 1'b0, 2'd1, 1'b1};
    tbl[5]  = '{3'b101, 1, 2,  1'b0, 1'b0, 2'd2, 1'b0};
    tbl[6]  = '{3'b001, 0, 0,  1'b0, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{3'b101, 2, 5,  1'b0, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{3'b011, 0, 1,  1'b0, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{3'b010, 0, 0,  1'b0, 1'b0, 2'd1, 1'b0};
    tbl[10] = '{3'b001, 3, 4,  1'b0, 1'b1, 2'd0, 1'b0};

    repeat (3) @(negedge rx_clock);
    chk("rst_ack", int'(ack), 0);
    chk("rst_start", int'(reply_start), 0);
    chk("rst_type", int'(reply_type), 0);
    chk("rst_err", int'(timeout_err), 0);
    chk("rst_busy", int'(sched_busy), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_reply(tbl[i]);

    wait_idle();
    tx_busy = 1'b1;
    req     = 3'b100;
    cnt     = 0;
    repeat (50) begin
      @(negedge rx_clock);
      if (reply_start) cnt++;
    end
    chk("busy_block", cnt, 0);
    chk("busy_idle", int'(sched_busy), 0);
    tx_busy = 1'b0;
    hv = '{3'b100, 0, 0, 1'b0, 1'b0, 2'd2, 1'b0};
    run_reply(hv);

    hv = '{3'b001, 0, 0, 1'b0, 1'b0, 2'd0, 1'b0};
    run_reply(hv);
    wait_idle();
    req = 3'b100;
    @(negedge rx_clock);
    chk("rs_start", int'(reply_start), 1);
    chk("rs_type", int'(reply_type), 2);
    tx_accept = 1'b1;
    @(negedge rx_clock);
    tx_accept = 1'b0;
    tx_busy   = 1'b1;
    @(negedge rx_clock);
    @(negedge rx_clock);
    chk("rs_in_send", int'(sched_busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_ack", int'(ack), 0);
    chk("rs_start0", int'(reply_start), 0);
    chk("rs_type0", int'(reply_type), 0);
    chk("rs_err0", int'(timeout_err), 0);
    chk("rs_busy0", int'(sched_busy), 0);
    @(negedge rx_clock);
    req     = 3'b011;
    tx_busy = 1'b0;
    @(negedge rx_clock);
    reset_n = 1'b1;
    hv = '{3'b011, 0, 0, 1'b0, 1'b0, 2'd0, 1'b0};
    run_reply(hv);
    hv = '{3'b010, 0, 0, 1'b0, 1'b0, 2'd1, 1'b0};
    run_reply(hv);

    wait_idle();
    repeat (5) @(negedge rx_clock);
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
